sw_debounce: RTL and testbench

- Upstream conditioning stage for the 4-to-2 priority encoder.
- Takes raw, asynchronous slide-switch inputs from the board: WIDTH data switches plus one enable switch.
- Synchronizes and debounces each of them.
- Produces glitch-free stable levels to drive the encoder's data and enable inputs, plus single-cycle rise and fall pulses for downstream display and counter logic.

---
 rtl/sw_debounce.sv | 80 ++++++++
 tb/tb_sw_debounce.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// Switch conditioning ahead of the 4-to-2 priority encoder: synchronizes and debounces
// WIDTH data switches plus one enable switch, and emits registered edge pulses.
module sw_debounce #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             en_in,
    output logic [WIDTH-1:0] x_out,
    output logic             en_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int unsigned NCH = WIDTH + 1;
    localparam int unsigned CW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Enable rides along as the top channel so every channel shares one update rule.
    logic [NCH-1:0] raw;
    assign raw = {en_in, sw_in};

    logic [NCH-1:0]         s1_q, s1_d;
    logic [NCH-1:0]         s2_q, s2_d;
    logic [NCH-1:0]         stable_q, stable_d;
    logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]       rise_q, rise_d;
    logic [WIDTH-1:0]       fall_q, fall_d;
    logic                   changed_q, changed_d;

    always_comb begin
        s1_d     = raw;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        rise_d    =  stable_d[WIDTH-1:0] & ~stable_q[WIDTH-1:0];
        fall_d    = ~stable_d[WIDTH-1:0] &  stable_q[WIDTH-1:0];
        changed_d = |(stable_d ^ stable_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            stable_q  <= '0;
            cnt_q     <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign x_out   = stable_q[WIDTH-1:0];
    assign en_out  = stable_q[WIDTH];
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce: expected output vectors are queued per cycle from
// the documented latency rules and compared against the DUT after each rising edge.
module tb_sw_debounce;

    typedef struct packed {
        logic [3:0] x;
        logic       en;
        logic [3:0] r;
        logic [3:0] f;
        logic       ch;
    } out_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw_in = '0;
    logic       en_in = 1'b0;

    logic [3:0] x_out, rise, fall;
    logic       en_out, changed;
    logic [3:0] x1_out, rise1, fall1;
    logic       en1_out, changed1;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    out_t        exp_q[$];

    always #5 clk = ~clk;

    sw_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .en_in(en_in),
        .x_out(x_out), .en_out(en_out), .rise(rise), .fall(fall), .changed(changed)
    );

    sw_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(1)) dut_min (
        .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .en_in(en_in),
        .x_out(x1_out), .en_out(en1_out), .rise(rise1), .fall(fall1), .changed(changed1)
    );

    function automatic out_t mk(logic [3:0] x, logic en, logic [3:0] r, logic [3:0] f, logic ch);
        out_t o;
        o.x = x; o.en = en; o.r = r; o.f = f; o.ch = ch;
        return o;
    endfunction

    function automatic out_t obs();
        return {x_out, en_out, rise, fall, changed};
    endfunction

    function automatic out_t obs_min();
        return {x1_out, en1_out, rise1, fall1, changed1};
    endfunction

    task automatic do_reset();
        sw_in = '0;
        en_in = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        out_t e;
        sw_in = 4'b1111;
        en_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL reset_hold cyc %0d: got {x,en,rise,fall,ch}=%b want %b", k, obs(), e);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k < 5)       exp_q.push_back(mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
            else if (k == 5) exp_q.push_back(mk(4'b1111, 1'b1, 4'b1111, 4'b0000, 1'b1));
            else             exp_q.push_back(mk(4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL reset_release cyc %0d: got {x,en,rise,fall,ch}=%b want %b", k, obs(), e);
            end
        end
    endtask

    task automatic test_clean_step();
        out_t e;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            sw_in = (k < 8) ? 4'b0100 : 4'b0000;
            if (k < 5)       exp_q.push_back(mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
            else if (k == 5) exp_q.push_back(mk(4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1));
            else if (k < 13) exp_q.push_back(mk(4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0));
            else if (k == 13) exp_q.push_back(mk(4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b1));
            else             exp_q.push_back(mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL clean_step cyc %0d: got {x,en,rise,fall,ch}=%b want %b", k, obs(), e);
            end
        end
    endtask

    task automatic test_glitch();
        out_t e;
        do_reset();
        // Three-cycle pulse falls one mismatch short of the threshold.
        for (int k = 0; k < 10; k++) begin
            sw_in = (k < 3) ? 4'b0010 : 4'b0000;
            exp_q.push_back(mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL glitch_short cyc %0d: got {x,en,rise,fall,ch}=%b want %b", k, obs(), e);
            end
        end
        for (int k = 0; k < 12; k++) begin
            sw_in = (k < 4) ? 4'b0010 : 4'b0000;
            if (k < 5)       exp_q.push_back(mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
            else if (k == 5) exp_q.push_back(mk(4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1));
            else if (k < 9)  exp_q.push_back(mk(4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0));
            else if (k == 9) exp_q.push_back(mk(4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b1));
            else             exp_q.push_back(mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL glitch_full cyc %0d: got {x,en,rise,fall,ch}=%b want %b", k, obs(), e);
            end
        end
    endtask

    task automatic test_bounce();
        out_t e;
        logic [4:0] pat;
        pat = 5'b10101;
        do_reset();
        for (int k = 0; k < 13; k++) begin
            en_in = (k < 5) ? pat[k] : 1'b1;
            if (k < 9)       exp_q.push_back(mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
            else if (k == 9) exp_q.push_back(mk(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1));
            else             exp_q.push_back(mk(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL bounce cyc %0d: got {x,en,rise,fall,ch}=%b want %b", k, obs(), e);
            end
        end
    endtask

    task automatic test_simultaneous();
        out_t e;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            sw_in = (k < 8) ? 4'b0011 : 4'b1100;
            if (k < 5)        exp_q.push_back(mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
            else if (k == 5)  exp_q.push_back(mk(4'b0011, 1'b0, 4'b0011, 4'b0000, 1'b1));
            else if (k < 13)  exp_q.push_back(mk(4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b0));
            else if (k == 13) exp_q.push_back(mk(4'b1100, 1'b0, 4'b1100, 4'b0011, 1'b1));
            else              exp_q.push_back(mk(4'b1100, 1'b0, 4'b0000, 4'b0000, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL simultaneous cyc %0d: got {x,en,rise,fall,ch}=%b want %b", k, obs(), e);
            end
        end
    endtask

    task automatic test_async_reset();
        out_t e;
        do_reset();
        sw_in = 4'b1000;
        en_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k < 5)       exp_q.push_back(mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
            else if (k == 5) exp_q.push_back(mk(4'b1000, 1'b1, 4'b1000, 4'b0000, 1'b1));
            else             exp_q.push_back(mk(4'b1000, 1'b1, 4'b0000, 4'b0000, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL async_setup cyc %0d: got {x,en,rise,fall,ch}=%b want %b", k, obs(), e);
            end
        end
        // Bit 0 rises; after the fourth edge its counter sits at 2.
        sw_in = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(mk(4'b1000, 1'b1, 4'b0000, 4'b0000, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL async_count cyc %0d: got {x,en,rise,fall,ch}=%b want %b", k, obs(), e);
            end
        end
        #2 rst_n = 1'b0;
        exp_q.push_back(mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL async_clear_now: got {x,en,rise,fall,ch}=%b want %b", obs(), e);
        end
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL async_hold cyc %0d: got {x,en,rise,fall,ch}=%b want %b", k, obs(), e);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k < 5)       exp_q.push_back(mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
            else if (k == 5) exp_q.push_back(mk(4'b1001, 1'b1, 4'b1001, 4'b0000, 1'b1));
            else             exp_q.push_back(mk(4'b1001, 1'b1, 4'b0000, 4'b0000, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL async_rerun cyc %0d: got {x,en,rise,fall,ch}=%b want %b", k, obs(), e);
            end
        end
    endtask

    task automatic test_min_latency();
        out_t e;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            sw_in = (k < 5) ? 4'b0110 : 4'b0000;
            en_in = (k < 5);
            if (k < 2)       exp_q.push_back(mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
            else if (k == 2) exp_q.push_back(mk(4'b0110, 1'b1, 4'b0110, 4'b0000, 1'b1));
            else if (k < 7)  exp_q.push_back(mk(4'b0110, 1'b1, 4'b0000, 4'b0000, 1'b0));
            else if (k == 7) exp_q.push_back(mk(4'b0000, 1'b0, 4'b0000, 4'b0110, 1'b1));
            else             exp_q.push_back(mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs_min() !== e) begin
                miscompares++;
                $display("FAIL min_latency cyc %0d: got {x,en,rise,fall,ch}=%b want %b", k, obs_min(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_async_reset();
        test_min_latency();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
